// File: rtl/serial_frame_deserializer_if.sv
// serial_frame_deserializer_if
//
// Purpose: bundles the serial input, the parallel valid/ready output and the
// status pulses of serial_frame_deserializer into one interface. Clock and
// reset are not part of this bundle; they stay plain ports on the module.
//
// Signals:
//   s_in        serial stream into the deserializer
//   data_out    assembled word, bit 0 is the first data bit received
//   data_valid  data_out holds a word that has not been consumed
//   data_ready  consumer takes the word when data_valid && data_ready
//   frame_err   one-cycle pulse, wrong stop bit
//   overrun     one-cycle pulse, good frame dropped because buffer was full
//   parity_err  one-cycle pulse, parity mismatch (0 when parity is not built)
//   busy        deserializer is inside a frame
//
// Modports:
//   master  the deserializer side (produces the parallel word)
//   slave   the environment side (drives the serial line and data_ready)

interface serial_frame_deserializer_if #(
  parameter int WIDTH = 4
);

  logic             s_in;
  logic [WIDTH-1:0] data_out;
  logic             data_valid;
  logic             data_ready;
  logic             frame_err;
  logic             overrun;
  logic             parity_err;
  logic             busy;

  modport master (
    input  s_in,
    input  data_ready,
    output data_out,
    output data_valid,
    output frame_err,
    output overrun,
    output parity_err,
    output busy
  );

  modport slave (
    output s_in,
    output data_ready,
    input  data_out,
    input  data_valid,
    input  frame_err,
    input  overrun,
    input  parity_err,
    input  busy
  );

endinterface

// File: rtl/serial_frame_deserializer.sv
// serial_frame_deserializer
//
// Purpose: watches a serial bit stream (one bit per clk) for framed words,
// assembles WIDTH data bits LSB first into a parallel word, and holds that
// word in a single-entry buffer offered to the consumer with valid/ready.
// Wrong stop bits, parity mismatches and dropped words are reported as
// one-cycle pulses.
//
// Frame: start (~STOP_LEVEL), WIDTH data bits LSB first, optional even
// parity bit, stop (STOP_LEVEL). The idle line sits at STOP_LEVEL.
//
// Optional feature macro: DESER_PARITY_CHECK_EN
//   defined   -> a PARITY state captures an even-parity bit after the data;
//                a mismatch pulses parity_err and drops the word.
//   undefined -> no PARITY state, parity_err is tied to 0.
//
// Ports:
//   clk    rising-edge clock, one serial bit per cycle
//   clear  synchronous active-high reset, priority over everything
//   bus    serial_frame_deserializer_if.master (s_in, data_out, data_valid,
//          data_ready, frame_err, overrun, parity_err, busy)
//
// Parameters:
//   WIDTH       data bits per frame, 2..16
//   STOP_LEVEL  required stop bit value and idle line level

module serial_frame_deserializer #(
  parameter int   WIDTH      = 4,
  parameter logic STOP_LEVEL = 1'b0
) (
  input  logic                           clk,
  input  logic                           clear,
  serial_frame_deserializer_if.master    bus
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

`ifdef DESER_PARITY_CHECK_EN
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    STOP   = 2'd3
  } state_t;
`endif

  state_t           state_q,     state_d;
  logic [CNT_W-1:0] bitCnt_q,    bitCnt_d;
  logic [WIDTH-1:0] shift_q,     shift_d;
  logic [WIDTH-1:0] dataOut_q,   dataOut_d;
  logic             dataValid_q, dataValid_d;
  logic             frameErr_q,  frameErr_d;
  logic             overrun_q,   overrun_d;
  logic             parityErr_q, parityErr_d;
`ifdef DESER_PARITY_CHECK_EN
  logic             parityBit_q, parityBit_d;
`endif

  logic stopOk;
  logic parityOk;
  logic canLoad;

  // Frame quality checks, only meaningful while in STOP. Even parity means
  // the XOR of all data bits and the parity bit is zero.
  assign stopOk = (bus.s_in == STOP_LEVEL);
`ifdef DESER_PARITY_CHECK_EN
  assign parityOk = ~(^shift_q ^ parityBit_q);
`else
  assign parityOk = 1'b1;
`endif

  // The single buffer slot is free if it is empty or is being handed to the
  // consumer on this very edge.
  assign canLoad = ~dataValid_q | bus.data_ready;

  // Next-state logic for the frame FSM, the output buffer and the status
  // pulses. Pulses default to 0 each cycle so they can never stretch.
  // data_valid defaults to "consumed if ready"; a load in STOP overrides it.
  always_comb begin
    state_d     = state_q;
    bitCnt_d    = bitCnt_q;
    shift_d     = shift_q;
    dataOut_d   = dataOut_q;
    dataValid_d = dataValid_q & ~bus.data_ready;
    frameErr_d  = 1'b0;
    overrun_d   = 1'b0;
    parityErr_d = 1'b0;
`ifdef DESER_PARITY_CHECK_EN
    parityBit_d = parityBit_q;
`endif

    case (state_q)
      IDLE: begin
        if (bus.s_in == ~STOP_LEVEL) begin
          state_d  = DATA;
          bitCnt_d = '0;
        end
      end

      DATA: begin
        shift_d[bitCnt_q] = bus.s_in;
        bitCnt_d          = bitCnt_q + 1'b1;
        if (bitCnt_q == LAST_BIT) begin
          bitCnt_d = '0;
`ifdef DESER_PARITY_CHECK_EN
          state_d  = PARITY;
`else
          state_d  = STOP;
`endif
        end
      end

`ifdef DESER_PARITY_CHECK_EN
      PARITY: begin
        parityBit_d = bus.s_in;
        state_d     = STOP;
      end
`endif

      // Always back to IDLE so a start bit on the very next cycle is caught.
      // Errors may pulse together; only a clean frame reaches the buffer.
      STOP: begin
        state_d     = IDLE;
        frameErr_d  = ~stopOk;
        parityErr_d = ~parityOk;
        if (stopOk && parityOk) begin
          if (canLoad) begin
            dataOut_d   = shift_q;
            dataValid_d = 1'b1;
          end else begin
            overrun_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers. clear wins over any frame in flight and
  // discards a word still waiting in the buffer.
  always_ff @(posedge clk) begin
    if (clear) begin
      state_q     <= IDLE;
      bitCnt_q    <= '0;
      shift_q     <= '0;
      dataOut_q   <= '0;
      dataValid_q <= 1'b0;
      frameErr_q  <= 1'b0;
      overrun_q   <= 1'b0;
      parityErr_q <= 1'b0;
`ifdef DESER_PARITY_CHECK_EN
      parityBit_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      bitCnt_q    <= bitCnt_d;
      shift_q     <= shift_d;
      dataOut_q   <= dataOut_d;
      dataValid_q <= dataValid_d;
      frameErr_q  <= frameErr_d;
      overrun_q   <= overrun_d;
      parityErr_q <= parityErr_d;
`ifdef DESER_PARITY_CHECK_EN
      parityBit_q <= parityBit_d;
`endif
    end
  end

  assign bus.data_out   = dataOut_q;
  assign bus.data_valid = dataValid_q;
  assign bus.frame_err  = frameErr_q;
  assign bus.overrun    = overrun_q;
`ifdef DESER_PARITY_CHECK_EN
  assign bus.parity_err = parityErr_q;
`else
  assign bus.parity_err = 1'b0;
`endif
  assign bus.busy       = (state_q != IDLE);

endmodule

// File: tb/tb_serial_frame_deserializer.sv
// tb_serial_frame_deserializer
//
// Purpose: drives serial_frame_deserializer with directed frames followed by
// random frames, gaps and consumer backpressure, and compares every output
// each cycle against a frame-level reference model.

module tb_serial_frame_deserializer;

  localparam int   WIDTH      = 4;
  localparam logic STOP_LEVEL = 1'b0;
  localparam int   RDY_RAND   = 2;

  logic clk;
  logic clear;

  serial_frame_deserializer_if #(.WIDTH(WIDTH)) bus ();

  serial_frame_deserializer #(
    .WIDTH      (WIDTH),
    .STOP_LEVEL (STOP_LEVEL)
  ) dut (
    .clk   (clk),
    .clear (clear),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Per-cycle stimulus plan. Each entry is one clk edge: the serial bit,
  // whether clear is asserted, the data_ready policy, and what the frame
  // layer says should be true after that edge.
  bit               qSin[$];
  bit               qClear[$];
  int               qReady[$];
  bit               qBusy[$];
  bit               qStop[$];
  bit               qStopBad[$];
  bit               qParBad[$];
  logic [WIDTH-1:0] qWord[$];

  int checkCount = 0;
  int passCount  = 0;

  // Reference model state: the single output buffer.
  logic             mValid;
  logic [WIDTH-1:0] mData;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got === exp) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic pushBit(input bit s, input bit clr, input int rdy, input bit busyAfter,
                         input bit isStop, input bit stopBad, input bit parBad,
                         input logic [WIDTH-1:0] w);
    qSin.push_back(s);
    qClear.push_back(clr);
    qReady.push_back(rdy);
    qBusy.push_back(busyAfter);
    qStop.push_back(isStop);
    qStopBad.push_back(stopBad);
    qParBad.push_back(parBad);
    qWord.push_back(w);
  endtask

  task automatic addIdle(input int n, input int rdy);
    for (int k = 0; k < n; k++) pushBit(STOP_LEVEL, 1'b0, rdy, 1'b0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic addClear(input int n);
    for (int k = 0; k < n; k++) pushBit(STOP_LEVEL, 1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  // Start bit plus the first nBits data bits, no stop; used to abort a frame.
  task automatic addPartial(input logic [WIDTH-1:0] data, input int nBits, input int rdy);
    pushBit(~STOP_LEVEL, 1'b0, rdy, 1'b1, 1'b0, 1'b0, 1'b0, '0);
    for (int k = 0; k < nBits; k++) pushBit(data[k], 1'b0, rdy, 1'b1, 1'b0, 1'b0, 1'b0, '0);
  endtask

  // Full frame after `gap` idle bits. parityBit is only sent when the
  // parity feature is built in.
  task automatic addFrame(input logic [WIDTH-1:0] data, input bit stopBit, input bit parityBit,
                          input int gap, input int rdy);
    bit parBad;
    addIdle(gap, rdy);
    addPartial(data, WIDTH, rdy);
`ifdef DESER_PARITY_CHECK_EN
    pushBit(parityBit, 1'b0, rdy, 1'b1, 1'b0, 1'b0, 1'b0, '0);
    parBad = ((^data) ^ parityBit) != 1'b0;
`else
    parBad = 1'b0;
    if (parityBit) parBad = 1'b0;
`endif
    pushBit(stopBit, 1'b0, rdy, 1'b0, 1'b1, stopBit != STOP_LEVEL, parBad, data);
  endtask

  // Drives one planned cycle, advances the model across the edge and
  // compares every output one time unit after the edge.
  task automatic applyStimulus(input int i);
    bit rdy;
    bit eFe, eOv, ePe;
    @(negedge clk);
    clear      = qClear[i];
    bus.s_in   = qSin[i];
    rdy        = (qReady[i] == RDY_RAND) ? 1'($urandom_range(0, 1)) : qReady[i][0];
    bus.data_ready = rdy;
    @(posedge clk);
    #1;
    eFe = 1'b0;
    eOv = 1'b0;
    ePe = 1'b0;
    if (qClear[i]) begin
      mValid = 1'b0;
      mData  = '0;
    end else begin
      if (mValid && rdy) mValid = 1'b0;
      if (qStop[i]) begin
        eFe = qStopBad[i];
        ePe = qParBad[i];
        if (!eFe && !ePe) begin
          if (!mValid) begin
            mValid = 1'b1;
            mData  = qWord[i];
          end else begin
            eOv = 1'b1;
          end
        end
      end
    end
    checkOutput($sformatf("data_valid[%0d]", i), 32'(bus.data_valid), 32'(mValid));
    checkOutput($sformatf("data_out[%0d]", i),   32'(bus.data_out),   32'(mData));
    checkOutput($sformatf("frame_err[%0d]", i),  32'(bus.frame_err),  32'(eFe));
    checkOutput($sformatf("overrun[%0d]", i),    32'(bus.overrun),    32'(eOv));
    checkOutput($sformatf("parity_err[%0d]", i), 32'(bus.parity_err), 32'(ePe));
    checkOutput($sformatf("busy[%0d]", i),       32'(bus.busy),       32'(qBusy[i] && !qClear[i]));
  endtask

  initial begin
    logic [WIDTH-1:0] d;
    bit               stopBit;
    bit               parBit;

    clear          = 1'b1;
    bus.s_in       = STOP_LEVEL;
    bus.data_ready = 1'b0;
    mValid         = 1'b0;
    mData          = '0;

    // Reset state.
    addClear(2);
    // Basic word D, then back-to-back D and 5 with no idle gap.
    addFrame(4'hD, STOP_LEVEL, ^(4'hD), 2, 1);
    addIdle(2, 1);
    addFrame(4'hD, STOP_LEVEL, ^(4'hD), 0, 1);
    addFrame(4'h5, STOP_LEVEL, ^(4'h5), 0, 1);
    // Framing error on A.
    addFrame(4'hA, ~STOP_LEVEL, ^(4'hA), 2, 1);
    // Overrun: 3 held, C dropped, then consumer drains 3.
    addFrame(4'h3, STOP_LEVEL, ^(4'h3), 2, 0);
    addFrame(4'hC, STOP_LEVEL, ^(4'hC), 1, 0);
    addIdle(2, 0);
    addIdle(3, 1);
    // clear after the second data bit of F, then a clean 6.
    addPartial(4'hF, 2, 1);
    addClear(1);
    addFrame(4'h6, STOP_LEVEL, ^(4'h6), 2, 1);
    // Clear also discards a held word.
    addFrame(4'h9, STOP_LEVEL, ^(4'h9), 2, 0);
    addClear(1);
    addIdle(2, 1);
    // Parity accept and reject on 7 (extra good frames without the feature).
    addFrame(4'h7, STOP_LEVEL, 1'b1, 2, 1);
    addFrame(4'h7, STOP_LEVEL, 1'b0, 2, 1);
    addIdle(2, 1);
    // Random frames, gaps, stop/parity errors and backpressure.
    for (int f = 0; f < 60; f++) begin
      d       = WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
      stopBit = ($urandom_range(0, 7) == 0) ? ~STOP_LEVEL : STOP_LEVEL;
      parBit  = ^d;
      if ($urandom_range(0, 7) == 0) parBit = ~parBit;
      addFrame(d, stopBit, parBit, $urandom_range(0, 3), RDY_RAND);
    end
    addIdle(4, 1);

    for (int i = 0; i < qSin.size(); i++) applyStimulus(i);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
